// File: rtl/capp_pkg.sv
// Shared CAPP parameters and the tag resolver state encoding.
package capp_pkg;

  localparam int unsigned CAPP_WORDS  = 100;
  localparam int unsigned CAPP_ADDR_W = 7;
  localparam int unsigned CAPP_CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } resolver_state_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: lowest set index, non-empty flag, and one-hot flag.
module lowest_set_encoder #(
  parameter int unsigned WORDS  = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic [WORDS-1:0]  vec,
  output logic [ADDR_W-1:0] idx,
  output logic              any,
  output logic              single
);

  logic found;
  logic multi;

  // Ascending scan: first hit sets idx, any later hit marks the vector as multi-bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (vec[i]) begin
        if (!found) idx = ADDR_W'(i);
        else        multi = 1'b1;
        found = 1'b1;
      end
    end
    any    = found;
    single = found && !multi;
  end

endmodule

// File: rtl/tag_resolver.sv
// Snapshots the tag vector and streams responder addresses, lowest first, over valid/ready.
module tag_resolver
  import capp_pkg::*;
#(
  parameter int unsigned WORDS  = CAPP_WORDS,
  parameter int unsigned ADDR_W = CAPP_ADDR_W,
  parameter int unsigned CNT_W  = CAPP_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORDS-1:0]  tags,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              some_none,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done
);

  resolver_state_t   state_q, state_d;
  logic [WORDS-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              some_none_q, some_none_d;
  logic              addr_valid_q, addr_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              hs;
  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_single;

  // Encoding the next snapshot lets addr/last be registered yet still track each accept.
  lowest_set_encoder #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_enc (
    .vec    (pending_d),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    some_none_d = some_none_q;
    hs          = addr_valid_q && addr_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d   = tags;
          count_d     = '0;
          some_none_d = |tags;
          state_d     = (|tags) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (hs) begin
          for (int i = 0; i < int'(WORDS); i++) begin
            if (ADDR_W'(i) == addr_q) pending_d[i] = 1'b0;
          end
          count_d = count_q + CNT_W'(1);
          if (last_q) state_d = DONE;
        end
        // A handshake in the abort cycle is still counted above.
        if (abort) begin
          pending_d = '0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_valid_d = (state_d == SCAN) && enc_any;
    addr_d       = addr_valid_d ? enc_idx : '0;
    last_d       = addr_valid_d && enc_single;
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      count_q      <= '0;
      some_none_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      some_none_q  <= some_none_d;
      addr_valid_q <= addr_valid_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign last       = last_q;
  assign some_none  = some_none_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tag_resolver.sv
// Self-checking bench for tag_resolver: queue-based reference model plus directed literal checks.
module tb_tag_resolver;

  localparam int WORDS  = 100;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 7;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [WORDS-1:0]  tags = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              addr_ready = 1'b0;
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              some_none;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;

  tag_resolver #(.WORDS(WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .tags       (tags),
    .start      (start),
    .abort      (abort),
    .addr_ready (addr_ready),
    .addr_valid (addr_valid),
    .addr       (addr),
    .last       (last),
    .some_none  (some_none),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int acc_q[$];

  // Reference model: 0 = idle, 1 = scanning, 2 = done; pending responders kept as an address queue.
  int m_mode = 0;
  int m_q[$];
  int m_cnt = 0;
  int m_some = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_mode = 0;
      m_q.delete();
      m_cnt  = 0;
      m_some = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_q.delete();
          for (int i = 0; i < WORDS; i++) if (tags[i]) m_q.push_back(i);
          m_cnt  = 0;
          m_some = (m_q.size() > 0) ? 1 : 0;
          m_mode = (m_q.size() > 0) ? 1 : 2;
        end
        1: begin
          if (addr_ready) begin
            void'(m_q.pop_front());
            m_cnt++;
            if (m_q.size() == 0) m_mode = 2;
          end
          if (abort) begin
            m_q.delete();
            m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("valid", addr_valid, (m_mode == 1) ? 1 : 0);
      chk("addr", addr, (m_mode == 1 && m_q.size() > 0) ? m_q[0] : 0);
      chk("last", last, (m_mode == 1 && m_q.size() == 1) ? 1 : 0);
      chk("some_none", some_none, m_some);
      chk("count", count, m_cnt % (1 << CNT_W));
      chk("busy", busy, (m_mode != 0) ? 1 : 0);
      chk("done", done, (m_mode == 2) ? 1 : 0);
      if (addr_valid && addr_ready) acc_q.push_back(int'(addr));
    end
  end

  task automatic do_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [WORDS-1:0] t);
    tags  = t;
    start = 1'b1;
    do_cycle();
    start = 1'b0;
  endtask

  // Returns the number of negedges seen up to and including the done pulse.
  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge CLK);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_seq(input string name, input int exp_q[$]);
    chk({name, "_len"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk({name, "_addr"}, acc_q[i], exp_q[i]);
  endtask

  task automatic run_abort(input logic rdy_at_abort, input int exp_cnt);
    int n;
    int e[$];
    acc_q.delete();
    addr_ready = 1'b1;
    pulse_start({WORDS{1'b1}});
    repeat (5) do_cycle();
    addr_ready = rdy_at_abort;
    abort = 1'b1;
    do_cycle();
    abort = 1'b0;
    addr_ready = 1'b1;
    wait_done(5, n);
    chk("abort_latency", n, 1);
    chk("abort_count", count, exp_cnt);
    for (int i = 0; i < exp_cnt; i++) e.push_back(i);
    chk_seq("abort_seq", e);
    do_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int e[$];
    logic [WORDS-1:0] t;

    // Reset
    RST_N = 1'b0;
    do_cycle();
    chk_en = 1'b1;
    do_cycle();
    @(negedge CLK);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    RST_N = 1'b1;
    do_cycle();

    // Basic resolve, including the top word
    acc_q.delete();
    addr_ready = 1'b1;
    t = '0; t[3] = 1'b1; t[17] = 1'b1; t[99] = 1'b1;
    pulse_start(t);
    wait_done(20, n);
    chk("basic_latency", n, 4);
    chk("basic_count", count, 3);
    chk("basic_some", some_none, 1);
    e = '{3, 17, 99};
    chk_seq("basic_seq", e);
    do_cycle();
    chk("basic_idle_busy", busy, 0);

    // No responders
    acc_q.delete();
    pulse_start('0);
    wait_done(5, n);
    chk("none_latency", n, 1);
    chk("none_some", some_none, 0);
    chk("none_count", count, 0);
    chk("none_accepts", acc_q.size(), 0);
    do_cycle();

    // Backpressure
    acc_q.delete();
    addr_ready = 1'b0;
    t = '0; t[0] = 1'b1; t[1] = 1'b1;
    pulse_start(t);
    repeat (3) begin
      @(negedge CLK);
      chk("stall_addr", addr, 0);
      chk("stall_valid", addr_valid, 1);
      do_cycle();
    end
    addr_ready = 1'b1;
    wait_done(10, n);
    chk("bp_latency", n, 3);
    chk("bp_count", count, 2);
    e = '{0, 1};
    chk_seq("bp_seq", e);
    do_cycle();

    // Abort without and with a coinciding handshake
    run_abort(1'b0, 5);
    run_abort(1'b1, 6);

    // Reset mid-scan, then a fresh start
    acc_q.delete();
    addr_ready = 1'b0;
    t = '0; t[5] = 1'b1; t[6] = 1'b1; t[7] = 1'b1;
    pulse_start(t);
    do_cycle();
    RST_N = 1'b0;
    do_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_valid", addr_valid, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_last", last, 0);
    chk("midrst_some", some_none, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    do_cycle();
    acc_q.delete();
    addr_ready = 1'b1;
    t = '0; t[2] = 1'b1; t[9] = 1'b1;
    pulse_start(t);
    wait_done(10, n);
    chk("fresh_latency", n, 3);
    e = '{2, 9};
    chk_seq("fresh_seq", e);
    do_cycle();

    // Start while busy is ignored
    acc_q.delete();
    t = '0; t[10] = 1'b1; t[20] = 1'b1; t[30] = 1'b1;
    pulse_start(t);
    t = '0; t[1] = 1'b1; t[2] = 1'b1;
    tags  = t;
    start = 1'b1;
    do_cycle();
    start = 1'b0;
    wait_done(10, n);
    chk("ign_count", count, 3);
    e = '{10, 20, 30};
    chk_seq("ign_seq", e);

    // Start during the done cycle is ignored, then taken in the first idle cycle
    acc_q.delete();
    t = '0; t[40] = 1'b1;
    tags  = t;
    start = 1'b1;
    do_cycle();
    chk("done_start_busy", busy, 0);
    do_cycle();
    start = 1'b0;
    wait_done(10, n);
    chk("idle_start_latency", n, 2);
    e = '{40};
    chk_seq("idle_start_seq", e);
    do_cycle();
    do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
